// File: rtl/fht_pkg.sv
// Shared defaults and narrowing helpers for the FHT Hartley butterfly.
// Define FHT_BUT_SAT_EN to saturate overflowing narrowings; otherwise they wrap.
package fht_pkg;

  localparam int unsigned FHT_D_BIT = 17;
  localparam int unsigned FHT_W_BIT = 12;

  typedef logic signed [63:0] wide_t;

  // Rounding constant added before the product shift (half of the twiddle unity).
  function automatic int unsigned half_w_max(input int unsigned w_bit);
    return 32'd1 << (w_bit - 3);
  endfunction

  // True when v does not fit in a signed w-bit word.
  function automatic logic ovf_chk(input wide_t v, input int unsigned w);
    wide_t max_v;
    wide_t min_v;
    max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    min_v = -(wide_t'(1) <<< (w - 1));
    return (v > max_v) || (v < min_v);
  endfunction

  // Narrow v to w bits; caller keeps the low w bits of the result.
  function automatic wide_t narrow(input wide_t v, input int unsigned w);
    wide_t r;
`ifdef FHT_BUT_SAT_EN
    if (ovf_chk(v, w)) begin
      r = v[63] ? -(wide_t'(1) <<< (w - 1)) : (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    end else begin
      r = v;
    end
`else
    r = (v <<< (64 - w)) >>> (64 - w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/fht_but_mac.sv
// Butterfly stage-1 datapath: twiddle multiply-accumulate, round, shift, narrow and bypass.
// Narrowing saturates under FHT_BUT_SAT_EN, otherwise wraps; mul_ovf is raised in both builds.
module fht_but_mac
  import fht_pkg::*;
#(
  parameter int unsigned D_BIT = FHT_D_BIT,
  parameter int unsigned W_BIT = FHT_W_BIT
) (
  input  logic signed [D_BIT-1:0] i_x1,
  input  logic signed [D_BIT-1:0] i_x2,
  input  logic signed [W_BIT-1:0] i_cos,
  input  logic signed [W_BIT-1:0] i_sin,
  input  logic                    i_bypass,
  output logic signed [D_BIT-1:0] o_m,
  output logic                    o_mul_ovf
);

  localparam int unsigned PW  = D_BIT + W_BIT + 1;
  localparam int unsigned RND = half_w_max(W_BIT);

  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_q;

  always_comb begin
    w_p = PW'(i_x1) * PW'(i_cos) + PW'(i_x2) * PW'(i_sin) + signed'(PW'(RND));
    // Drop the twiddle unity scaling; the bits above D_BIT must be pure sign.
    w_q = w_p >>> (W_BIT - 2);
    if (i_bypass) begin
      o_m       = i_x1;
      o_mul_ovf = 1'b0;
    end else begin
      o_m       = D_BIT'(narrow(wide_t'(w_q), D_BIT));
      o_mul_ovf = ovf_chk(wide_t'(w_q), D_BIT);
    end
  end

endmodule

// File: rtl/fht_but_pipe.sv
// Two-stage pipelined radix-2 Hartley butterfly with valid/ready flow control and sticky overflow.
// FHT_BUT_SAT_EN selects saturating (defined) or wrapping (undefined) narrowing.
module fht_but_pipe
  import fht_pkg::*;
#(
  parameter int unsigned D_BIT = FHT_D_BIT,
  parameter int unsigned W_BIT = FHT_W_BIT
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iVALID,
  output logic                    oREADY,
  input  logic                    iBYPASS,
  input  logic                    iSCALE,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic signed [W_BIT-1:0] iCOS,
  output logic                    oVALID,
  input  logic                    iREADY,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1,
  output logic                    oOVF,
  input  logic                    iOVF_CLR
);

  localparam int unsigned SW = D_BIT + 1;

  logic                    w_adv;
  logic signed [D_BIT-1:0] w_m;
  logic                    w_mul_ovf;

  logic                    r_s1_vld;
  logic                    r_s1_scale;
  logic                    r_s1_mul_ovf;
  logic signed [D_BIT-1:0] r_s1_x0;
  logic signed [D_BIT-1:0] r_s1_m;

  logic signed [SW-1:0]    w_s;
  logic signed [SW-1:0]    w_d;
  logic signed [D_BIT-1:0] w_y0;
  logic signed [D_BIT-1:0] w_y1;
  logic                    w_add_ovf;
  logic                    w_ovf_set;

  logic                    r_vld;
  logic signed [D_BIT-1:0] r_y0;
  logic signed [D_BIT-1:0] r_y1;
  logic                    r_ovf;

  // Single global enable: the whole pipe moves only when the output slot can drain.
  assign w_adv  = ~r_vld | iREADY;
  assign oREADY = w_adv;

  fht_but_mac #(
    .D_BIT(D_BIT),
    .W_BIT(W_BIT)
  ) u_mac (
    .i_x1     (iX_1),
    .i_x2     (iX_2),
    .i_cos    (iCOS),
    .i_sin    (iSIN),
    .i_bypass (iBYPASS),
    .o_m      (w_m),
    .o_mul_ovf(w_mul_ovf)
  );

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_s1_vld     <= 1'b0;
      r_s1_scale   <= 1'b0;
      r_s1_mul_ovf <= 1'b0;
      r_s1_x0      <= '0;
      r_s1_m       <= '0;
    end else if (w_adv) begin
      r_s1_vld     <= iVALID;
      r_s1_scale   <= iSCALE;
      r_s1_mul_ovf <= w_mul_ovf;
      r_s1_x0      <= iX_0;
      r_s1_m       <= w_m;
    end
  end

  always_comb begin
    w_s       = SW'(r_s1_x0) + SW'(r_s1_m);
    w_d       = SW'(r_s1_x0) - SW'(r_s1_m);
    w_add_ovf = 1'b0;
    if (r_s1_scale) begin
      // Halving with round-half-up cannot leave the D_BIT range.
      w_y0 = D_BIT'((w_s + SW'(1)) >>> 1);
      w_y1 = D_BIT'((w_d + SW'(1)) >>> 1);
    end else begin
      w_y0      = D_BIT'(narrow(wide_t'(w_s), D_BIT));
      w_y1      = D_BIT'(narrow(wide_t'(w_d), D_BIT));
      w_add_ovf = ovf_chk(wide_t'(w_s), D_BIT) | ovf_chk(wide_t'(w_d), D_BIT);
    end
    w_ovf_set = w_adv & r_s1_vld & (r_s1_mul_ovf | w_add_ovf);
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_vld <= 1'b0;
      r_y0  <= '0;
      r_y1  <= '0;
    end else if (w_adv) begin
      r_vld <= r_s1_vld;
      r_y0  <= w_y0;
      r_y1  <= w_y1;
    end
  end

  // A new overflow outranks a simultaneous clear request.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (iOVF_CLR) begin
      r_ovf <= 1'b0;
    end
  end

  assign oVALID = r_vld;
  assign oY_0   = r_y0;
  assign oY_1   = r_y1;
  assign oOVF   = r_ovf;

endmodule

// File: tb/tb_fht_but_pipe.sv
// Directed, table-driven bench for fht_but_pipe plus backpressure, set/clear and reset sequences.
module tb_fht_but_pipe;

  logic               iCLK = 1'b0;
  logic               iRESET = 1'b0;
  logic               iVALID = 1'b0;
  logic               oREADY;
  logic               iBYPASS = 1'b0;
  logic               iSCALE = 1'b0;
  logic signed [16:0] iX_0 = '0;
  logic signed [16:0] iX_1 = '0;
  logic signed [16:0] iX_2 = '0;
  logic signed [11:0] iSIN = '0;
  logic signed [11:0] iCOS = '0;
  logic               oVALID;
  logic               iREADY = 1'b1;
  logic signed [16:0] oY_0;
  logic signed [16:0] oY_1;
  logic               oOVF;
  logic               iOVF_CLR = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int x0, x1, x2, cs, sn, byp, sc;
    int y0, y1, ovf;
  } vec_t;

`ifdef FHT_BUT_SAT_EN
  localparam int Y0_POS_OVF = 65535;
  localparam int Y1_NEG_OVF = -65536;
  localparam int Y0_MUL_OVF = 32768;
  localparam int Y1_MUL_OVF = -32767;
`else
  localparam int Y0_POS_OVF = -61072;
  localparam int Y1_NEG_OVF = 61072;
  localparam int Y0_MUL_OVF = -32768;
  localparam int Y1_MUL_OVF = 32768;
`endif

  fht_but_pipe #(
    .D_BIT(17),
    .W_BIT(12)
  ) dut (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .iVALID  (iVALID),
    .oREADY  (oREADY),
    .iBYPASS (iBYPASS),
    .iSCALE  (iSCALE),
    .iX_0    (iX_0),
    .iX_1    (iX_1),
    .iX_2    (iX_2),
    .iSIN    (iSIN),
    .iCOS    (iCOS),
    .oVALID  (oVALID),
    .iREADY  (iREADY),
    .oY_0    (oY_0),
    .oY_1    (oY_1),
    .oOVF    (oOVF),
    .iOVF_CLR(iOVF_CLR)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iX_0    = 17'(v.x0);
    iX_1    = 17'(v.x1);
    iX_2    = 17'(v.x2);
    iCOS    = 12'(v.cs);
    iSIN    = 12'(v.sn);
    iBYPASS = v.byp[0];
    iSCALE  = v.sc[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    vec_t v;
    int   lat;
    int   sent, got, stall, stall_seen, late_vld;
    logic acc;
    int   gy0[$];
    int   gy1[$];

    vt[0] = '{100, 200, 0, 1024, 0, 0, 1, 150, -50, 0};
    vt[1] = '{-100, 300, 0, 0, 0, 1, 0, 200, -400, 0};
    vt[1].cs = int'($urandom_range(4095)) - 2048;
    vt[1].sn = int'($urandom_range(4095)) - 2048;
    vt[1].x2 = int'($urandom_range(65535)) - 32768;
    vt[2] = '{0, 3, 0, 512, 0, 0, 0, 2, -2, 0};
    vt[3] = '{60000, 10000, 0, 0, 0, 1, 0, Y0_POS_OVF, 50000, 1};
    vt[4] = '{0, 0, 1000, 0, -1024, 0, 0, -1000, 1000, 0};
    vt[5] = '{-10, 1000, 500, 724, 724, 0, 0, 1051, -1071, 0};
    vt[6] = '{-3, 0, 0, 0, 0, 1, 1, -1, -1, 0};
    vt[7] = '{-60000, 10000, 0, 0, 0, 1, 0, -50000, Y1_NEG_OVF, 1};
    vt[8] = '{0, -65536, 0, -1024, 0, 0, 1, Y0_MUL_OVF, Y1_MUL_OVF, 1};

    // Reset state
    #12;
    chk("reset oVALID", oVALID, 0);
    chk("reset oY_0", oY_0, 0);
    chk("reset oY_1", oY_1, 0);
    chk("reset oOVF", oOVF, 0);
    chk("reset oREADY", oREADY, 1);
    @(negedge iCLK);
    iRESET = 1'b1;

    // Single-sample vectors
    for (int i = 0; i < 9; i++) begin
      v = vt[i];
      @(negedge iCLK);
      drive(v);
      iVALID = 1'b1;
      chk($sformatf("vec%0d oREADY", i), oREADY, 1);
      @(negedge iCLK);
      iVALID = 1'b0;
      lat = 1;
      while (!oVALID && lat < 6) begin
        @(negedge iCLK);
        lat++;
      end
      chk($sformatf("vec%0d latency", i), lat, 2);
      chk($sformatf("vec%0d oY_0", i), oY_0, v.y0);
      chk($sformatf("vec%0d oY_1", i), oY_1, v.y1);
      chk($sformatf("vec%0d oOVF", i), oOVF, v.ovf);
      repeat (2) @(negedge iCLK);
      chk($sformatf("vec%0d oOVF sticky", i), oOVF, v.ovf);
      iOVF_CLR = 1'b1;
      @(negedge iCLK);
      iOVF_CLR = 1'b0;
      chk($sformatf("vec%0d oOVF cleared", i), oOVF, 0);
    end

    // Set and clear in the same cycle: set wins, clear applies next
    @(negedge iCLK);
    iOVF_CLR = 1'b1;
    drive(vt[3]);
    iVALID = 1'b1;
    @(negedge iCLK);
    iVALID = 1'b0;
    @(negedge iCLK);
    chk("setwins oVALID", oVALID, 1);
    chk("setwins oOVF", oOVF, 1);
    @(negedge iCLK);
    chk("clear after set", oOVF, 0);
    iOVF_CLR = 1'b0;

    // Backpressure: 4 back-to-back samples, stall 2 cycles with sample 2 at the output
    sent = 0; got = 0; stall = 0; stall_seen = 0; acc = 1'b0;
    iBYPASS = 1'b1;
    iSCALE  = 1'b0;
    iX_2    = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge iCLK);
      if (acc) sent++;
      iREADY = !(oVALID && oY_0 == 17'sd22 && stall < 2);
      if (!iREADY) stall++;
      iVALID = (sent < 4);
      iX_0   = 17'(10 * (sent + 1));
      iX_1   = 17'(sent + 1);
      #1;
      if (!iREADY) begin
        stall_seen++;
        chk("stall oREADY", oREADY, 0);
        chk("stall hold oY_0", oY_0, 22);
        chk("stall hold oY_1", oY_1, 18);
      end
      acc = iVALID && oREADY;
      if (oVALID && iREADY) begin
        gy0.push_back(int'(oY_0));
        gy1.push_back(int'(oY_1));
        got++;
      end
    end
    iVALID = 1'b0;
    iREADY = 1'b1;
    chk("bp stall cycles", stall_seen, 2);
    chk("bp delivered", got, 4);
    for (int k = 0; k < 4 && k < got; k++) begin
      chk($sformatf("bp sample%0d oY_0", k + 1), gy0[k], 11 * (k + 1));
      chk($sformatf("bp sample%0d oY_1", k + 1), gy1[k], 9 * (k + 1));
    end
    chk("bp oOVF", oOVF, 0);

    // Reset mid-stream with an overflowed sample at the output and another in flight
    @(negedge iCLK);
    drive(vt[3]);
    iVALID = 1'b1;
    @(negedge iCLK);
    iX_0 = 17'sd5;
    iX_1 = 17'sd5;
    @(negedge iCLK);
    iVALID = 1'b0;
    chk("pre-reset oVALID", oVALID, 1);
    chk("pre-reset oOVF", oOVF, 1);
    #1;
    iRESET = 1'b0;
    #1;
    chk("async reset oVALID", oVALID, 0);
    chk("async reset oY_0", oY_0, 0);
    chk("async reset oY_1", oY_1, 0);
    chk("async reset oOVF", oOVF, 0);
    @(negedge iCLK);
    iRESET = 1'b1;
    late_vld = 0;
    repeat (4) begin
      @(negedge iCLK);
      if (oVALID) late_vld++;
    end
    chk("no stale sample after reset", late_vld, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
